// File: rtl/clint_mc_pkg.sv
// Shared types, constants and helpers for the multi-source core-local interruptor.
// Contents: bus widths, reset/divider encodings, SYSTEM instruction encodings,
// CSR addresses, synchronous cause codes, FSM/decision enums and mstatus/trap-target helpers.
package clint_mc_pkg;

    localparam int INST_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int REG_W      = 32;
    localparam int MEM_ADDR_W = 32;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic DIV_START  = 1'b1;

    localparam logic [INST_W-1:0] INST_NOP    = 32'h0000_0013;
    localparam logic [INST_W-1:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [INST_W-1:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [INST_W-1:0] INST_MRET   = 32'h3020_0073;

    localparam logic [MEM_ADDR_W-1:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [MEM_ADDR_W-1:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [MEM_ADDR_W-1:0] CSR_MCAUSE  = 32'h0000_0342;

    localparam logic [REG_W-1:0] CAUSE_ECALL  = 32'd11;
    localparam logic [REG_W-1:0] CAUSE_EBREAK = 32'd3;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MCAUSE  = 3'd2,
        S_W_MSTATUS = 3'd3,
        S_W_MRET    = 3'd4
    } clint_state_e;

    typedef enum logic [1:0] {
        DEC_NONE  = 2'd0,
        DEC_SYNC  = 2'd1,
        DEC_ASYNC = 2'd2,
        DEC_MRET  = 2'd3
    } clint_dec_e;

    // Trap entry: stash MIE into MPIE and mask further interrupts.
    function automatic logic [REG_W-1:0] mstatus_on_trap(input logic [REG_W-1:0] m);
        logic [REG_W-1:0] r;
        r                   = m;
        r[MSTATUS_MPIE_BIT] = m[MSTATUS_MIE_BIT];
        r[MSTATUS_MIE_BIT]  = 1'b0;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE and set MPIE.
    function automatic logic [REG_W-1:0] mstatus_on_mret(input logic [REG_W-1:0] m);
        logic [REG_W-1:0] r;
        r                   = m;
        r[MSTATUS_MIE_BIT]  = m[MSTATUS_MPIE_BIT];
        r[MSTATUS_MPIE_BIT] = 1'b1;
        return r;
    endfunction

    // Only asynchronous traps use the vector table; the cause MSB is not part of the offset.
    function automatic logic [ADDR_W-1:0] trap_target(input logic [REG_W-1:0] mtvec,
                                                      input logic             is_async,
                                                      input logic [REG_W-1:0] cause);
        logic [ADDR_W-1:0] base;
        base = {mtvec[31:2], 2'b00};
        if ((mtvec[1:0] == 2'b01) && is_async) begin
            return base + {cause[29:0], 2'b00};
        end else begin
            return base;
        end
    endfunction

endpackage

// File: rtl/clint_mc_if.sv
// CSR write / redirect bus from the interruptor to csr_reg and ex.
// master: interruptor side (drives); slave: consumer side.
//   we, waddr, data  - registered CSR write
//   int_assert       - one-cycle redirect pulse
//   int_addr         - redirect target (0 when not asserting)
interface clint_mc_if;
    import clint_mc_pkg::*;

    logic                  we;
    logic [MEM_ADDR_W-1:0] waddr;
    logic [REG_W-1:0]      data;
    logic                  int_assert;
    logic [ADDR_W-1:0]     int_addr;

    modport master (output we, waddr, data, int_assert, int_addr);
    modport slave  (input  we, waddr, data, int_assert, int_addr);
endinterface

// File: rtl/clint_mc_irq_arb.sv
// Interrupt source front end: edge detection, pending latches and winner selection.
// Ports: clk_i, rst_ni (sync, active-high), irq_i (raw lines), mie_i (per-source enable),
//        claim_i (current winner accepted this cycle), valid_o / id_o / onehot_o (winner).
module clint_irq_arb
    import clint_mc_pkg::*;
#(
    parameter int          NUM_SRC  = 8,
    parameter logic [31:0] SRC_EDGE = 32'h0000_0001,
    parameter bit          ARB_RR   = 1'b0,
    localparam int         IDW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
)(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic [NUM_SRC-1:0] mie_i,
    input  logic               claim_i,
    output logic               valid_o,
    output logic [IDW-1:0]     id_o,
    output logic [NUM_SRC-1:0] onehot_o
);

    localparam logic [NUM_SRC-1:0] EDGE_MASK = SRC_EDGE[NUM_SRC-1:0];

    logic [NUM_SRC-1:0] irq_prev_q;
    logic [NUM_SRC-1:0] edge_pend_q, edge_pend_d;
    logic [NUM_SRC-1:0] cand_s, onehot_s;
    logic [IDW-1:0]     ptr_q, ptr_d, id_s;
    logic               valid_s;

    // Pending set and next-state of the edge latches; a fresh edge wins over a same-cycle claim.
    always_comb begin
        cand_s      = ((edge_pend_q & EDGE_MASK) | (irq_i & ~EDGE_MASK)) & mie_i;
        edge_pend_d = ((edge_pend_q & ~(claim_i ? onehot_s : '0)) | (irq_i & ~irq_prev_q)) & EDGE_MASK;
    end

    // Winner search: from index 0 (fixed) or from the rotating pointer with wrap (round-robin).
    always_comb begin : p_pick
        int idx;
        valid_s  = 1'b0;
        id_s     = '0;
        onehot_s = '0;
        idx      = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (ARB_RR ? int'(ptr_q) : 0) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end else begin
                idx = idx;
            end
            if (!valid_s && cand_s[idx]) begin
                valid_s = 1'b1;
                id_s    = IDW'(idx);
            end else begin
                valid_s = valid_s;
            end
        end
        onehot_s[id_s] = valid_s;
    end

    // Round-robin pointer advances to the slot after the accepted winner.
    always_comb begin
        if (ARB_RR && claim_i && valid_s) begin
            ptr_d = (int'(id_s) == NUM_SRC - 1) ? '0 : id_s + IDW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Edge history, pending latches and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_ni == RST_ENABLE) begin
            irq_prev_q  <= '0;
            edge_pend_q <= '0;
            ptr_q       <= '0;
        end else begin
            irq_prev_q  <= irq_i;
            edge_pend_q <= edge_pend_d;
            ptr_q       <= ptr_d;
        end
    end

    assign valid_o  = valid_s;
    assign id_o     = id_s;
    assign onehot_o = onehot_s;

endmodule

// File: rtl/clint_mc.sv
// Multi-source core-local interruptor: takes ECALL/EBREAK/MRET and NUM_SRC interrupt lines,
// holds the pipeline, writes mepc/mcause/mstatus in sequence and redirects ex.
// Ports: clk_i, rst_ni (sync, active-high), irq_i, inst_i/inst_addr_i (id stage),
//        jump_flag_i/jump_addr_i (ex redirect), div_started_i, csr_mtvec_i/csr_mepc_i/csr_mstatus_i,
//        csr_mie_i, global_int_en_i, hold_flag_o, csr_if (CSR write + redirect bus),
//        irq_claim_o (one-hot accept pulse), int_id_o (last accepted source).
module clint_mc
    import clint_mc_pkg::*;
#(
    parameter int          NUM_SRC        = 8,
    parameter logic [31:0] SRC_EDGE       = 32'h0000_0001,
    parameter bit          ARB_RR         = 1'b0,
    parameter int          IRQ_CAUSE_BASE = 16,
    localparam int         IDW            = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
)(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic [INST_W-1:0]  inst_i,
    input  logic [ADDR_W-1:0]  inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [ADDR_W-1:0]  jump_addr_i,
    input  logic               div_started_i,
    input  logic [REG_W-1:0]   csr_mtvec_i,
    input  logic [REG_W-1:0]   csr_mepc_i,
    input  logic [REG_W-1:0]   csr_mstatus_i,
    input  logic [NUM_SRC-1:0] csr_mie_i,
    input  logic               global_int_en_i,
    output logic               hold_flag_o,
    clint_mc_if.master         csr_if,
    output logic [NUM_SRC-1:0] irq_claim_o,
    output logic [IDW-1:0]     int_id_o
);

    clint_state_e          state_q, state_d;
    clint_dec_e            dec_s;
    logic [ADDR_W-1:0]     epc_q, epc_d;
    logic [REG_W-1:0]      cause_q, cause_d;
    logic                  async_q, async_d;
    logic                  we_q, we_d, int_assert_q, int_assert_d;
    logic [MEM_ADDR_W-1:0] waddr_q, waddr_d;
    logic [REG_W-1:0]      data_q, data_d;
    logic [ADDR_W-1:0]     int_addr_q, int_addr_d;
    logic [NUM_SRC-1:0]    claim_q, claim_d, arb_onehot_s;
    logic [IDW-1:0]        id_q, id_d, arb_id_s;
    logic                  arb_valid_s, is_sync_s;

    clint_irq_arb #(
        .NUM_SRC  (NUM_SRC),
        .SRC_EDGE (SRC_EDGE),
        .ARB_RR   (ARB_RR)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .irq_i    (irq_i),
        .mie_i    (csr_mie_i),
        .claim_i  (dec_s == DEC_ASYNC),
        .valid_o  (arb_valid_s),
        .id_o     (arb_id_s),
        .onehot_o (arb_onehot_s)
    );

    // IDLE decision; a synchronous trap during a divide blocks everything until the divider is done.
    always_comb begin
        is_sync_s = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
        if (state_q != S_IDLE) begin
            dec_s = DEC_NONE;
        end else if (is_sync_s) begin
            dec_s = (div_started_i == DIV_START) ? DEC_NONE : DEC_SYNC;
        end else if (arb_valid_s && global_int_en_i) begin
            dec_s = DEC_ASYNC;
        end else if (inst_i == INST_MRET) begin
            dec_s = DEC_MRET;
        end else begin
            dec_s = DEC_NONE;
        end
    end

    assign hold_flag_o = (dec_s != DEC_NONE) || (state_q != S_IDLE);

    // Next state, trap context capture and next values of the registered bus outputs.
    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        async_d      = async_q;
        claim_d      = '0;
        id_d         = id_q;
        we_d         = 1'b0;
        waddr_d      = '0;
        data_d       = '0;
        int_assert_d = 1'b0;
        int_addr_d   = '0;
        case (state_q)
            S_IDLE: begin
                case (dec_s)
                    DEC_SYNC: begin
                        state_d = S_W_MEPC;
                        async_d = 1'b0;
                        epc_d   = jump_flag_i ? (jump_addr_i - 32'd4) : inst_addr_i;
                        cause_d = (inst_i == INST_EBREAK) ? CAUSE_EBREAK : CAUSE_ECALL;
                    end
                    DEC_ASYNC: begin
                        state_d = S_W_MEPC;
                        async_d = 1'b1;
                        // Interrupted instruction is re-executed: jump target, or the one before a busy divide.
                        epc_d   = jump_flag_i ? jump_addr_i :
                                  ((div_started_i == DIV_START) ? (inst_addr_i - 32'd4) : inst_addr_i);
                        cause_d = {1'b1, 31'(IRQ_CAUSE_BASE) + 31'(arb_id_s)};
                        claim_d = arb_onehot_s;
                        id_d    = arb_id_s;
                    end
                    DEC_MRET: begin
                        state_d = S_W_MRET;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_W_MEPC: begin
                we_d    = 1'b1;
                waddr_d = CSR_MEPC;
                data_d  = epc_q;
                state_d = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                we_d    = 1'b1;
                waddr_d = CSR_MCAUSE;
                data_d  = cause_q;
                state_d = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                we_d         = 1'b1;
                waddr_d      = CSR_MSTATUS;
                data_d       = mstatus_on_trap(csr_mstatus_i);
                int_assert_d = 1'b1;
                int_addr_d   = trap_target(csr_mtvec_i, async_q, cause_q);
                state_d      = S_IDLE;
            end
            S_W_MRET: begin
                we_d         = 1'b1;
                waddr_d      = CSR_MSTATUS;
                data_d       = mstatus_on_mret(csr_mstatus_i);
                int_assert_d = 1'b1;
                int_addr_d   = csr_mepc_i;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, trap context and output registers; reset abandons any partial sequence.
    always_ff @(posedge clk_i) begin
        if (rst_ni == RST_ENABLE) begin
            state_q      <= S_IDLE;
            epc_q        <= '0;
            cause_q      <= '0;
            async_q      <= 1'b0;
            claim_q      <= '0;
            id_q         <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            data_q       <= '0;
            int_assert_q <= 1'b0;
            int_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            async_q      <= async_d;
            claim_q      <= claim_d;
            id_q         <= id_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            data_q       <= data_d;
            int_assert_q <= int_assert_d;
            int_addr_q   <= int_addr_d;
        end
    end

    assign csr_if.we         = we_q;
    assign csr_if.waddr      = waddr_q;
    assign csr_if.data       = data_q;
    assign csr_if.int_assert = int_assert_q;
    assign csr_if.int_addr   = int_addr_q;
    assign irq_claim_o       = claim_q;
    assign int_id_o          = id_q;

endmodule

// File: tb/tb_clint_mc.sv
// Self-checking bench for clint_mc: a fixed-priority and a round-robin instance share stimulus;
// expected CSR writes, redirects and claims are queued when stimulus is applied and popped as
// the selected instance produces them.
module tb_clint_mc;
    import clint_mc_pkg::*;

    localparam int NS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] irq, mie;
    logic [31:0]   inst, inst_addr, jump_addr, mtvec, mepc, mstatus;
    logic          jump, div, gie;
    logic          hold_fx, hold_rr;
    logic [NS-1:0] claim_fx, claim_rr;
    logic [2:0]    id_fx, id_rr;

    clint_mc_if if_fx();
    clint_mc_if if_rr();

    clint_mc #(.NUM_SRC(NS), .SRC_EDGE(32'h0000_0001), .ARB_RR(1'b0), .IRQ_CAUSE_BASE(16)) u_dut (
        .clk_i(clk), .rst_ni(rst), .irq_i(irq), .inst_i(inst), .inst_addr_i(inst_addr),
        .jump_flag_i(jump), .jump_addr_i(jump_addr), .div_started_i(div), .csr_mtvec_i(mtvec),
        .csr_mepc_i(mepc), .csr_mstatus_i(mstatus), .csr_mie_i(mie), .global_int_en_i(gie),
        .hold_flag_o(hold_fx), .csr_if(if_fx), .irq_claim_o(claim_fx), .int_id_o(id_fx));

    clint_mc #(.NUM_SRC(NS), .SRC_EDGE(32'h0000_0001), .ARB_RR(1'b1), .IRQ_CAUSE_BASE(16)) u_dut_rr (
        .clk_i(clk), .rst_ni(rst), .irq_i(irq), .inst_i(inst), .inst_addr_i(inst_addr),
        .jump_flag_i(jump), .jump_addr_i(jump_addr), .div_started_i(div), .csr_mtvec_i(mtvec),
        .csr_mepc_i(mepc), .csr_mstatus_i(mstatus), .csr_mie_i(mie), .global_int_en_i(gie),
        .hold_flag_o(hold_rr), .csr_if(if_rr), .irq_claim_o(claim_rr), .int_id_o(id_rr));

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;

    wr_t           q_wr_fx[$], q_wr_rr[$];
    logic [31:0]   q_rd_fx[$], q_rd_rr[$];
    logic [NS-1:0] q_cl_fx[$], q_cl_rr[$];
    int n_cmp = 0, n_err = 0, cyc = 0, last_assert_cyc = -1, n_assert = 0, acc = 0, n_before = 0;
    bit mon_fx = 1'b1, mon_rr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause, input logic [31:0] ms,
                             input logic [31:0] tgt, input bit rr);
        wr_t w0, w1, w2;
        w0 = {CSR_MEPC, epc};
        w1 = {CSR_MCAUSE, cause};
        w2 = {CSR_MSTATUS, ms};
        if (rr) begin
            q_wr_rr.push_back(w0); q_wr_rr.push_back(w1); q_wr_rr.push_back(w2); q_rd_rr.push_back(tgt);
        end else begin
            q_wr_fx.push_back(w0); q_wr_fx.push_back(w1); q_wr_fx.push_back(w2); q_rd_fx.push_back(tgt);
        end
    endtask

    task automatic mon_dut(input bit rr, input logic we, input logic [31:0] wa, input logic [31:0] wd,
                           input logic ia, input logic [31:0] iaddr, input logic [NS-1:0] cl);
        wr_t e; logic [31:0] r; logic [NS-1:0] c; int sz;
        if (we) begin
            sz = rr ? q_wr_rr.size() : q_wr_fx.size();
            n_cmp++;
            assert (sz > 0) else begin n_err++; $error("FAIL unexp_write observed=%h/%h expected=none", wa, wd); end
            if (sz > 0) begin
                if (rr) e = q_wr_rr.pop_front(); else e = q_wr_fx.pop_front();
                chk("csr_waddr", wa, e.addr);
                chk("csr_wdata", wd, e.data);
            end
        end
        if (ia) begin
            last_assert_cyc = cyc;
            n_assert++;
            sz = rr ? q_rd_rr.size() : q_rd_fx.size();
            n_cmp++;
            assert (sz > 0) else begin n_err++; $error("FAIL unexp_redirect observed=%h expected=none", iaddr); end
            if (sz > 0) begin
                if (rr) r = q_rd_rr.pop_front(); else r = q_rd_fx.pop_front();
                chk("int_addr", iaddr, r);
            end
        end else begin
            chk("int_addr_idle", iaddr, 32'h0);
        end
        if (cl != '0) begin
            sz = rr ? q_cl_rr.size() : q_cl_fx.size();
            n_cmp++;
            assert (sz > 0) else begin n_err++; $error("FAIL unexp_claim observed=%h expected=none", cl); end
            if (sz > 0) begin
                if (rr) c = q_cl_rr.pop_front(); else c = q_cl_fx.pop_front();
                chk("irq_claim", 32'(cl), 32'(c));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mon_fx) mon_dut(1'b0, if_fx.we, if_fx.waddr, if_fx.data, if_fx.int_assert, if_fx.int_addr, claim_fx);
        if (mon_rr) mon_dut(1'b1, if_rr.we, if_rr.waddr, if_rr.data, if_rr.int_assert, if_rr.int_addr, claim_rr);
    endtask

    initial begin
        irq = '0; mie = 8'hFF; inst = INST_NOP; inst_addr = 32'h100; jump = 1'b0; jump_addr = 32'h0;
        div = 1'b0; gie = 1'b1; mtvec = 32'h1000; mepc = 32'h200; mstatus = 32'h8;

        // Reset state
        rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
        chk("rst_we", 32'(if_fx.we), 32'h0);
        chk("rst_int_assert", 32'(if_fx.int_assert), 32'h0);
        chk("rst_claim", 32'(claim_fx), 32'h0);
        chk("rst_id", 32'(id_fx), 32'h0);
        chk("rst_hold", 32'(hold_fx), 32'h0);
        chk("rst_rr_we", 32'(if_rr.we), 32'h0);

        // ECALL at 0x100
        inst = INST_ECALL; #1;
        chk("ecall_hold", 32'(hold_fx), 32'h1);
        push_trap(32'h100, 32'd11, 32'h80, 32'h1000, 1'b0);
        tick(); acc = cyc; inst = INST_NOP; #1;
        chk("busy_hold", 32'(hold_fx), 32'h1);
        repeat (4) tick();
        chk("ecall_latency", 32'(last_assert_cyc), 32'(acc + 3));
        chk("idle_hold", 32'(hold_fx), 32'h0);

        // Edge src0 + level src3 together, fixed priority; masked first so both are pending
        gie = 1'b0; irq = 8'h09; inst_addr = 32'h200; tick(); tick();
        chk("masked_hold", 32'(hold_fx), 32'h0);
        push_trap(32'h200, 32'h8000_0010, 32'h80, 32'h1000, 1'b0); q_cl_fx.push_back(8'h01);
        gie = 1'b1; #1;
        chk("async_hold", 32'(hold_fx), 32'h1);
        tick(); acc = cyc; gie = 1'b0; irq = 8'h08;
        repeat (4) tick();
        chk("src0_latency", 32'(last_assert_cyc), 32'(acc + 3));
        chk("src0_id", 32'(id_fx), 32'h0);

        // MRET while src3 is still pending but interrupts are masked
        mstatus = 32'h80; mepc = 32'h204; inst = INST_MRET;
        q_wr_fx.push_back({CSR_MSTATUS, 32'h88}); q_rd_fx.push_back(32'h204);
        tick(); acc = cyc; inst = INST_NOP;
        repeat (2) tick();
        chk("mret_latency", 32'(last_assert_cyc), 32'(acc + 1));

        // src3 now claimed
        mstatus = 32'h8; gie = 1'b1;
        push_trap(32'h200, 32'h8000_0013, 32'h80, 32'h1000, 1'b0); q_cl_fx.push_back(8'h08);
        tick(); gie = 1'b0; irq = 8'h00;
        repeat (4) tick();
        chk("src3_id", 32'(id_fx), 32'h3);
        chk("fx_wr_empty", 32'(q_wr_fx.size()), 32'h0);

        // Round-robin: level sources 1, 2, 5 held high
        mon_fx = 1'b0; mon_rr = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        irq = 8'h26; inst_addr = 32'h300;
        push_trap(32'h300, 32'h8000_0011, 32'h80, 32'h1000, 1'b1); q_cl_rr.push_back(8'h02);
        push_trap(32'h300, 32'h8000_0012, 32'h80, 32'h1000, 1'b1); q_cl_rr.push_back(8'h04);
        push_trap(32'h300, 32'h8000_0015, 32'h80, 32'h1000, 1'b1); q_cl_rr.push_back(8'h20);
        push_trap(32'h300, 32'h8000_0011, 32'h80, 32'h1000, 1'b1); q_cl_rr.push_back(8'h02);
        gie = 1'b1;
        repeat (16) tick();
        gie = 1'b0; irq = 8'h00;
        repeat (3) tick();
        chk("rr_id", 32'(id_rr), 32'h1);
        chk("rr_wr_empty", 32'(q_wr_rr.size()), 32'h0);
        chk("rr_cl_empty", 32'(q_cl_rr.size()), 32'h0);
        rst = 1'b1; tick(); rst = 1'b0; mon_rr = 1'b0; mon_fx = 1'b1;

        // Vectored mtvec, source 2
        mtvec = 32'h8001; irq = 8'h04; inst_addr = 32'h400; gie = 1'b1;
        push_trap(32'h400, 32'h8000_0012, 32'h80, 32'h8048, 1'b0); q_cl_fx.push_back(8'h04);
        tick(); gie = 1'b0; irq = 8'h00;
        repeat (4) tick();
        chk("vec_id", 32'(id_fx), 32'h2);
        mtvec = 32'h1000;

        // EBREAK deferred while the divider is busy
        inst = INST_EBREAK; div = 1'b1; inst_addr = 32'h500; #1;
        chk("ebreak_div_hold", 32'(hold_fx), 32'h0);
        repeat (3) tick();
        div = 1'b0; #1;
        chk("ebreak_hold", 32'(hold_fx), 32'h1);
        push_trap(32'h500, 32'd3, 32'h80, 32'h1000, 1'b0);
        tick(); inst = INST_NOP;
        repeat (4) tick();

        // ECALL while ex redirects
        inst = INST_ECALL; jump = 1'b1; jump_addr = 32'h604;
        push_trap(32'h600, 32'd11, 32'h80, 32'h1000, 1'b0);
        tick(); inst = INST_NOP; jump = 1'b0;
        repeat (4) tick();

        // Async while the divider is busy
        div = 1'b1; irq = 8'h10; inst_addr = 32'h700; gie = 1'b1;
        push_trap(32'h6FC, 32'h8000_0014, 32'h80, 32'h1000, 1'b0); q_cl_fx.push_back(8'h10);
        tick(); gie = 1'b0; irq = 8'h00; div = 1'b0;
        repeat (4) tick();

        // Reset during W_MCAUSE with an edge source pending
        irq = 8'h01; tick(); tick(); irq = 8'h00;
        inst = INST_ECALL; q_wr_fx.push_back({CSR_MEPC, 32'h700});
        n_before = n_assert;
        tick(); inst = INST_NOP;
        tick();
        rst = 1'b1; tick();
        chk("midrst_we", 32'(if_fx.we), 32'h0);
        chk("midrst_int_assert", 32'(if_fx.int_assert), 32'h0);
        rst = 1'b0; gie = 1'b1; #1;
        chk("midrst_pending_hold", 32'(hold_fx), 32'h0);
        repeat (6) tick();
        chk("midrst_no_assert", 32'(n_assert), 32'(n_before));
        gie = 1'b0;

        chk("end_wr_empty", 32'(q_wr_fx.size()), 32'h0);
        chk("end_rd_empty", 32'(q_rd_fx.size()), 32'h0);
        chk("end_cl_empty", 32'(q_cl_fx.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
